// File: rtl/core_pkg.sv
// Shared types for the pipeline hazard controller.
package core_pkg;

    localparam int               REG_AW   = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN,
        LU,
        MWAIT
    } hz_state_t;

    typedef struct packed {
        logic              valid;
        logic              regWrite;
        logic              isLoad;
        logic [REG_AW-1:0] rd;
    } stage_track_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/execute side-band signals into and control signals out of the hazard unit.
interface hazard_ctrl_if #(
    parameter int AW = 5,
    parameter int CW = 32
);
    logic [AW-1:0] rs1D_i;
    logic [AW-1:0] rs2D_i;
    logic          useRs1D_i;
    logic          useRs2D_i;
    logic          regWriteD_i;
    logic [AW-1:0] AD3D_i;
    logic          resultSrcD_i;
    logic          branchTakenE_i;
    logic          memBusy_i;
    logic          enF_o;
    logic          enD_o;
    logic          enE_o;
    logic          flushD_o;
    logic          flushE_o;
    logic [1:0]    fwdAE_o;
    logic [1:0]    fwdBE_o;
    logic [CW-1:0] stallCnt_o;
    logic [CW-1:0] flushCnt_o;

    // Pipeline side: drives decode/execute status, consumes controls.
    modport master (
        output rs1D_i, rs2D_i, useRs1D_i, useRs2D_i, regWriteD_i, AD3D_i,
               resultSrcD_i, branchTakenE_i, memBusy_i,
        input  enF_o, enD_o, enE_o, flushD_o, flushE_o, fwdAE_o, fwdBE_o,
               stallCnt_o, flushCnt_o
    );

    // Hazard controller side.
    modport slave (
        input  rs1D_i, rs2D_i, useRs1D_i, useRs2D_i, regWriteD_i, AD3D_i,
               resultSrcD_i, branchTakenE_i, memBusy_i,
        output enF_o, enD_o, enE_o, flushD_o, flushE_o, fwdAE_o, fwdBE_o,
               stallCnt_o, flushCnt_o
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, clocked with the pipeline (negedge).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise increment until all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(negedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: stall/flush/enable generation and execute-stage forwarding
// for the 5-stage core, with private E/M/W destination tracking.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int REGISTER_ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH              = 32
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hz
);
    stage_track_t                      e_q, m_q, w_q;
    logic [REGISTER_ADDRESS_WIDTH-1:0] eRs1_q, eRs2_q;
    hz_state_t                         state_q, state_d;

    logic ldUse, advance, stallInc, flushInc;
    logic enF, enD, enE, flushD, flushE;

    // Load in E whose destination the decode instruction reads.
    assign ldUse = e_q.valid && e_q.isLoad && (e_q.rd != REG_ZERO) &&
                   ((hz.useRs1D_i && (hz.rs1D_i == e_q.rd)) ||
                    (hz.useRs2D_i && (hz.rs2D_i == e_q.rd)));

    // Forward select for one execute operand; loads in M are never taken from M.
    function automatic fwd_sel_t fwd_pick(input logic [REGISTER_ADDRESS_WIDTH-1:0] rs);
        if (m_q.valid && m_q.regWrite && !m_q.isLoad && (m_q.rd != REG_ZERO) && (m_q.rd == rs))
            return FWD_M;
        else if (w_q.valid && w_q.regWrite && (w_q.rd != REG_ZERO) && (w_q.rd == rs))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

    // Event priority rst > memBusy > redirect > load-use, then next-state per state.
    always_comb begin
        enF      = 1'b1;
        enD      = 1'b1;
        enE      = 1'b1;
        flushD   = 1'b0;
        flushE   = 1'b0;
        advance  = 1'b1;
        stallInc = 1'b0;
        flushInc = 1'b0;
        state_d  = RUN;
        if (rst) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (hz.memBusy_i) begin
            enF     = 1'b0;
            enD     = 1'b0;
            enE     = 1'b0;
            advance = 1'b0;
            state_d = MWAIT;
        end else if (hz.branchTakenE_i) begin
            flushD   = 1'b1;
            flushE   = 1'b1;
            flushInc = 1'b1;
        end else begin
            // RUN and LU both re-arm on a hazard against the current E; MWAIT
            // resumes with whatever decode presents on release.
            unique case (state_q)
                RUN, LU, MWAIT: state_d = ldUse ? LU : RUN;
                default:        state_d = RUN;
            endcase
            if (ldUse) begin
                enF      = 1'b0;
                enD      = 1'b0;
                flushE   = 1'b1;
                stallInc = 1'b1;
            end
        end
    end

    // Tracking slots shift with the pipeline; a flushed E becomes an all-zero bubble.
    always_ff @(negedge clk) begin
        if (rst) begin
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
            eRs1_q  <= '0;
            eRs2_q  <= '0;
            state_q <= RUN;
        end else begin
            state_q <= state_d;
            if (advance) begin
                w_q <= m_q;
                m_q <= e_q;
                if (flushE) begin
                    e_q    <= '0;
                    eRs1_q <= '0;
                    eRs2_q <= '0;
                end else begin
                    e_q    <= '{valid: 1'b1, regWrite: hz.regWriteD_i,
                                isLoad: hz.resultSrcD_i, rd: hz.AD3D_i};
                    eRs1_q <= hz.rs1D_i;
                    eRs2_q <= hz.rs2D_i;
                end
            end
        end
    end

    sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (stallInc),
        .cnt_o (hz.stallCnt_o)
    );

    sat_counter #(.W(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (flushInc),
        .cnt_o (hz.flushCnt_o)
    );

    assign hz.enF_o    = enF;
    assign hz.enD_o    = enD;
    assign hz.enE_o    = enE;
    assign hz.flushD_o = flushD;
    assign hz.flushE_o = flushE;
    assign hz.fwdAE_o  = rst ? FWD_RF : fwd_pick(eRs1_q);
    assign hz.fwdBE_o  = rst ? FWD_RF : fwd_pick(eRs2_q);
endmodule
